// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit subtractor: D = A - B - Bin, one bit per clock, LSB first.
//   A start/busy/done handshake frames each operation. The difference and the
//   borrow-out are registered and held until the next operation completes.
//
//   Timing: start accepted at edge E0 -> busy for N cycles -> done pulses in
//   the cycle after edge E0+N, with d/bout already updated in that cycle.
//   A start during the done cycle is accepted, so back-to-back operations
//   run at one result per N+1 cycles.
//
//   Optional feature macro: SUB_OVF_EN
//     defined   -> adds output ovf (two's-complement overflow of the result)
//     undefined -> no ovf port and no MSB capture logic
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout
`ifdef SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  // A counter of at least one bit keeps N=1 legal.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [N-1:0]   r_a_sr;      // minuend, consumed LSB first
  logic [N-1:0]   r_b_sr;      // subtrahend, consumed LSB first
  logic [N-1:0]   r_res;       // difference bits, filled from the MSB end
  logic           r_borrow;    // running borrow between bit positions
  logic [CW-1:0]  r_cnt;       // index of the bit being processed
  logic [N-1:0]   r_d;
  logic           r_bout;

  logic           w_x;
  logic           w_y;
  logic           w_diff;
  logic           w_borrow_next;
  logic [N-1:0]   w_res_next;
  logic           w_last;
  logic           w_accept;

  // ---- single-bit full subtractor on the current LSBs -----------------------
  assign w_x           = r_a_sr[0];
  assign w_y           = r_b_sr[0];
  assign w_diff        = w_x ^ w_y ^ r_borrow;
  assign w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

  // The new bit enters at the MSB; after N shifts bit 0 sits at position 0.
  generate
    if (N == 1) begin : g_res_one
      assign w_res_next = w_diff;
    end else begin : g_res_wide
      assign w_res_next = {w_diff, r_res[N-1:1]};
    end
  endgenerate

  assign w_last   = (r_cnt == CW'(N - 1));
  // A start is taken whenever no bit-serial pass is in flight, which
  // includes the done cycle (back-to-back operation).
  assign w_accept = start && (r_state != S_SHIFT);

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign d    = r_d;
  assign bout = r_bout;

  // Next-state decode for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    // NOTE: assigning a default before the case guarantees every path drives
    // the signal, so no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_SHIFT : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset wins over any simultaneous start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Operand capture on accept, then one shift per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_res    <= '0;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res    <= w_res_next;
      r_borrow <= w_borrow_next;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Publish the result on the final bit so it is visible during done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d    <= '0;
      r_bout <= 1'b0;
    end else if ((r_state == S_SHIFT) && w_last) begin
      r_d    <= w_res_next;
      r_bout <= w_borrow_next;
    end
  end

`ifdef SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  assign ovf = r_ovf;

  // Operand sign bits are kept because the shift registers lose them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[N-1];
      r_b_msb <= b[N-1];
    end
  end

  // Overflow: operand signs differ and the result sign differs from A's.
  // The last computed bit is the result MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_SHIFT) && w_last) begin
      r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_diff);
    end
  end
`endif

endmodule
